// File: rtl/pipe_m_stage_mc_pkg.sv
// Shared definitions for the memory stage: FSM encoding, widths, E/M bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t (IDLE/REQ), RN_W/DATA_W/CNT_W widths, ERR_DATA_DEF,
//           em_bundle_t (E/M pipeline register payload), word_aligned().
package pipe_defs;

  localparam int RN_W   = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Payload carried from E to M.
  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] b;
    logic [RN_W-1:0]   rn;
  } em_bundle_t;

  // Word accesses only: the two address LSBs must be zero.
  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/pipe_m_stage_mc_if.sv
// Data-memory request/acknowledge bus between the M stage and data memory.
// Latency: n/a (wires only).
// Backpressure: req is held until a one-cycle ack; addr/we/wdata stay stable meanwhile.
// Signals: req, we, addr, wdata (stage -> memory); rdata, ack (memory -> stage).
interface pipe_m_stage_mc_if;
  import pipe_defs::*;

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/pipe_m_stage_mc_em_reg.sv
// E/M pipeline register: captures the E bundle when enabled, holds otherwise.
// Latency: 1 cycle.
// Backpressure: en_i low (memory stall) freezes the contents.
// Ports: clock, resetn (async active-low clear), en_i, d_i (E bundle), q_o (M bundle).
module pipe_em_reg
  import pipe_defs::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       en_i,
  input  em_bundle_t d_i,
  output em_bundle_t q_o
);

  em_bundle_t bundle_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bundle_q <= '0;
    end else if (en_i) begin
      bundle_q <= d_i;
    end
  end

  assign q_o = bundle_q;

endmodule

// File: rtl/pipe_m_stage_mc.sv
// Memory stage: E/M register, req/ack data-memory access, pipeline stall, M bundle.
// Latency: 1 cycle E->M for non-memory ops; loads/stores complete in the ack cycle.
// Backpressure: mem_stall (combinational) holds the front of the pipe while a request waits.
// Ports: clock/resetn; E inputs ewreg/em2reg/ewmem/ealu/eb/ern; dmem bus (master modport);
//        outputs mem_stall, mwreg, mm2reg, malu, mmo, mrn, mem_err.
module pipe_m_stage_mc
  import pipe_defs::*;
#(
  parameter int                MAX_WAIT = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                ewreg,
  input  logic                em2reg,
  input  logic                ewmem,
  input  logic [DATA_W-1:0]   ealu,
  input  logic [DATA_W-1:0]   eb,
  input  logic [RN_W-1:0]     ern,
  pipe_m_stage_mc_if.master   dmem,
  output logic                mem_stall,
  output logic                mwreg,
  output logic                mm2reg,
  output logic [DATA_W-1:0]   malu,
  output logic [DATA_W-1:0]   mmo,
  output logic [RN_W-1:0]     mrn,
  output logic                mem_err
);

  // Wait count at which an unanswered request is abandoned.
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(MAX_WAIT - 1);

  em_bundle_t        e_bus;
  em_bundle_t        m_bus;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mmo_q, mmo_d;

  logic              in_req;
  logic              ack_hit;
  logic              timeout;
  logic              misalign;
  logic              e_go;

  assign e_bus = '{wreg: ewreg, m2reg: em2reg, wmem: ewmem, alu: ealu, b: eb, rn: ern};

  pipe_em_reg u_em_reg (
    .clock  (clock),
    .resetn (resetn),
    .en_i   (~mem_stall),
    .d_i    (e_bus),
    .q_o    (m_bus)
  );

  always_comb begin
    in_req   = (state_q == REQ);
    ack_hit  = in_req & dmem.ack;
    timeout  = in_req & (cnt_q == TMO_CNT);
    // Ack and timeout are both completion events, so either releases the pipe.
    mem_stall = in_req & ~dmem.ack & ~timeout;
    // Misaligned ops never enter REQ, so they are only ever seen from IDLE.
    misalign = ~in_req & (m_bus.m2reg | m_bus.wmem) & ~word_aligned(m_bus.alu[1:0]);
    // The op being captured this edge decides whether the next cycle requests,
    // so a memory op is already in REQ during its first cycle in M.
    e_go     = (ewmem | em2reg) & word_aligned(ealu[1:0]);

    // Ack wins over a coincident timeout.
    mmo_d = mmo_q;
    if (ack_hit) begin
      mmo_d = dmem.rdata;
    end else if (timeout) begin
      mmo_d = ERR_DATA;
    end else if (misalign & m_bus.m2reg) begin
      mmo_d = ERR_DATA;
    end

    err_d = err_q | (timeout & ~dmem.ack) | misalign;

    if (mem_stall) begin
      state_d = REQ;
      cnt_d   = cnt_q + 1'b1;
    end else begin
      state_d = e_go ? REQ : IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      mmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mmo_q   <= mmo_d;
    end
  end

  assign dmem.req   = in_req;
  assign dmem.we    = m_bus.wmem;
  assign dmem.addr  = m_bus.alu;
  assign dmem.wdata = m_bus.b;

  // Load data is bypassed in the ack cycle so W sees it without an extra cycle.
  assign mmo     = mmo_d;
  assign mwreg   = m_bus.wreg & ~mem_stall;
  assign mm2reg  = m_bus.m2reg;
  assign malu    = m_bus.alu;
  assign mrn     = m_bus.rn;
  assign mem_err = err_q;

endmodule
